// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, round-count constants, FSM states and GF(2^8)/S-box helpers
package aes_pkg;

    typedef logic [127:0] aes_block_t;

    localparam int AES128_NR = 10;
    localparam int AES192_NR = 12;
    localparam int AES256_NR = 14;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_state_e;

    // Forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// aes_round_comb: one combinational AES round
//   st_in/rk -> st_out; final_rnd bypasses MixColumns. Byte i sits at [127-8i -: 8], row i%4, column i/4.
module aes_round_comb
    import aes_pkg::*;
(
    input  aes_block_t st_in,
    input  aes_block_t rk,
    input  logic       final_rnd,
    output aes_block_t st_out
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    always_comb begin
        for (int i = 0; i < 16; i++) sb[i] = sbox(st_in[127 - 8 * i -: 8]);
        // Row r rotates left by r columns.
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[4 * c + r] = sb[4 * ((c + r) % 4) + r];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                mc[4 * c + r] = gf_mul2(sr[4 * c + r]) ^ gf_mul3(sr[4 * c + (r + 1) % 4])
                              ^ sr[4 * c + (r + 2) % 4] ^ sr[4 * c + (r + 3) % 4];
        st_out = '0;
        for (int i = 0; i < 16; i++)
            st_out[127 - 8 * i -: 8] = (final_rnd ? sr[i] : mc[i]) ^ rk[127 - 8 * i -: 8];
    end

endmodule

// File: rtl/aes_enc_iter.sv
// aes_enc_iter: iterative AES encryptor, one round per clock, round keys fetched by index
//   in_valid/in_ready/in_block: plaintext handshake; rk_idx/rk_data: round-key read port
//   out_valid/out_ready/out_block: ciphertext handshake; busy: block in flight
module aes_enc_iter
    import aes_pkg::*;
#(
    parameter int NR = AES128_NR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy
);

    if (NR != AES128_NR && NR != AES192_NR && NR != AES256_NR) begin : g_bad_nr
        $error("aes_enc_iter: NR must be 10, 12 or 14");
    end

    aes_state_e state_q, state_d;
    logic [3:0] rnd_q, rnd_d;
    aes_block_t st_q, st_d;
    logic       out_valid_q, out_valid_d;
    aes_block_t round_out;
    logic       final_rnd;

    assign final_rnd = rnd_q == 4'(NR);

    aes_round_comb u_round (
        .st_in     (st_q),
        .rk        (rk_data),
        .final_rnd (final_rnd),
        .st_out    (round_out)
    );

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        st_d    = st_q;
        case (state_q)
            IDLE: if (in_valid) begin
                st_d    = in_block ^ rk_data;
                rnd_d   = 4'd1;
                state_d = ROUND;
            end
            ROUND: begin
                st_d = round_out;
                if (final_rnd) state_d = DONE;
                else rnd_d = rnd_q + 4'd1;
            end
            DONE: if (out_ready) begin
                state_d = IDLE;
                rnd_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        out_valid_d = state_d == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rnd_q       <= '0;
            st_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            st_q        <= st_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign out_valid = out_valid_q;
    assign out_block = st_q;
    assign rk_idx    = state_q == ROUND ? rnd_q : state_q == DONE ? 4'(NR) : 4'd0;

endmodule

// File: tb/tb_aes_enc_iter.sv
// tb_aes_enc_iter: self-checking bench for aes_enc_iter at NR=10/12/14 against a byte-level AES model
module tb_aes_enc_iter;

    localparam logic [255:0] KEY_B   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] KEY_C1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_C2  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_C    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C2   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 0, rst_n = 0, out_ready = 0;
    logic [127:0] in_block = '0;
    logic [2:0]   iv = '0, ir, ov, bz;
    logic [3:0]   ridx [3];
    logic [127:0] rdat [3], ob [3];
    logic [127:0] rks [3][16];
    logic [7:0]   tsb [256];

    int checks = 0, errors = 0, cyc = 0, ov_seen = 0;
    int acc_cyc [$];
    logic [127:0] got [$];

    assign rdat[0] = rks[0][ridx[0]];
    assign rdat[1] = rks[1][ridx[1]];
    assign rdat[2] = rks[2][ridx[2]];

    aes_enc_iter #(.NR(10)) u10 (.clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_block(in_block),
        .rk_idx(ridx[0]), .rk_data(rdat[0]), .out_valid(ov[0]), .out_ready(out_ready), .out_block(ob[0]), .busy(bz[0]));
    aes_enc_iter #(.NR(12)) u12 (.clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_block(in_block),
        .rk_idx(ridx[1]), .rk_data(rdat[1]), .out_valid(ov[1]), .out_ready(out_ready), .out_block(ob[1]), .busy(bz[1]));
    aes_enc_iter #(.NR(14)) u14 (.clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_block(in_block),
        .rk_idx(ridx[2]), .rk_data(rdat[2]), .out_valid(ov[2]), .out_ready(out_ready), .out_block(ob[2]), .busy(bz[2]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change #1 after posedge, so negedge sees what the next edge will act on.
    always @(negedge clk) begin
        if (iv[0] && ir[0]) acc_cyc.push_back(cyc);
        if (ov[0] && out_ready) got.push_back(ob[0]);
        if (ov[0]) ov_seen++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box from first principles: multiplicative inverse followed by the affine map.
    task automatic build_sbox;
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = '0;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            tsb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {tsb[t[31:24]], tsb[t[23:16]], tsb[t[15:8]], tsb[t[7:0]]};
    endfunction

    task automatic expand(input int k, input logic [255:0] key, input int nr);
        logic [31:0] w [64];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk;
        nk = nr - 6;
        rc = 8'h01;
        for (int i = 0; i < 64; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) t = subw(t);
            w[i] = w[i - nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            if (r <= nr) rks[k][r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
            else rks[k][r] = '0;
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input int k, input int nr);
        logic [7:0]   s [16], u [16];
        logic [127:0] key, res;
        key = rks[k][0];
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ key[127 - 8 * i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) u[i] = tsb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) s[4 * c + w] = u[4 * ((c + w) % 4) + w];
            if (r < nr) begin
                for (int i = 0; i < 16; i++) u[i] = s[i];
                for (int c = 0; c < 4; c++)
                    for (int w = 0; w < 4; w++)
                        s[4 * c + w] = gmul(u[4 * c + w], 8'h02) ^ gmul(u[4 * c + (w + 1) % 4], 8'h03)
                                     ^ u[4 * c + (w + 2) % 4] ^ u[4 * c + (w + 3) % 4];
            end
            key = rks[k][r];
            for (int i = 0; i < 16; i++) s[i] ^= key[127 - 8 * i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128;
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] r1, blks [4];
        int w, base;
        build_sbox();
        expand(0, KEY_B, 10);
        expand(1, KEY_C2, 12);
        expand(2, KEY_C3, 14);
        repeat (2) tick();
        rst_n = 1;
        tick();

        chk("rst_in_ready", ir[0], 1);
        chk("rst_out_valid", ov[0], 0);
        chk("rst_busy", bz[0], 0);
        chk("rst_out_block", ob[0], 0);
        chk("rst_rk_idx", ridx[0], 0);

        // FIPS-197 App. B with cycle-exact latency and key index sequence.
        in_block = PT_B;
        iv[0] = 1;
        tick();
        iv[0] = 0;
        for (int t = 1; t <= 10; t++) begin
            chk("b_rk_idx", ridx[0], t);
            chk("b_busy", bz[0], 1);
            chk("b_in_ready", ir[0], 0);
            chk("b_early_valid", ov[0], 0);
            tick();
        end
        chk("b_valid_lat", ov[0], 1);
        chk("b_ct", ob[0], CT_B);
        chk("b_rk_idx_done", ridx[0], 10);

        // Backpressure with a new block waiting.
        r1 = rand128();
        in_block = r1;
        iv[0] = 1;
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("bp_valid", ov[0], 1);
            chk("bp_block", ob[0], CT_B);
            chk("bp_in_ready", ir[0], 0);
            chk("bp_rk_idx", ridx[0], 10);
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("hs_valid_drop", ov[0], 0);
        chk("hs_in_ready", ir[0], 1);
        chk("hs_busy", bz[0], 0);
        tick();
        // in_valid and in_block wander while the rounds run.
        for (int t = 1; t <= 10; t++) begin
            chk("tog_rk_idx", ridx[0], t);
            iv[0] = 1'($urandom_range(0, 1));
            in_block = rand128();
            tick();
        end
        iv[0] = 0;
        chk("tog_valid", ov[0], 1);
        chk("tog_ct", ob[0], aes_ref(r1, 0, 10));
        out_ready = 1;
        tick();

        // Back-to-back stream with out_ready held high.
        acc_cyc.delete();
        got.delete();
        for (int n = 0; n < 4; n++) blks[n] = rand128();
        for (int n = 0; n < 4; n++) begin
            in_block = blks[n];
            iv[0] = 1;
            w = 0;
            while (!ir[0] && w < 30) begin
                tick();
                w++;
            end
            chk("b2b_accept_wait", w < 30, 1);
            tick();
        end
        iv[0] = 0;
        w = 0;
        while (got.size() < 4 && w < 40) begin
            tick();
            w++;
        end
        chk("b2b_count", got.size(), 4);
        for (int n = 0; n < 4 && n < got.size(); n++) chk("b2b_ct", got[n], aes_ref(blks[n], 0, 10));
        for (int n = 1; n < 4 && n < acc_cyc.size(); n++) chk("b2b_spacing", acc_cyc[n] - acc_cyc[n - 1], 12);

        // Reset mid-round, then a fresh App. B block.
        out_ready = 0;
        in_block = PT_B;
        iv[0] = 1;
        tick();
        iv[0] = 0;
        repeat (4) tick();
        chk("abort_rk_idx", ridx[0], 5);
        base = ov_seen;
        #2 rst_n = 0;
        #1;
        chk("abort_in_ready", ir[0], 1);
        chk("abort_out_valid", ov[0], 0);
        chk("abort_busy", bz[0], 0);
        chk("abort_out_block", ob[0], 0);
        chk("abort_rk_idx0", ridx[0], 0);
        tick();
        rst_n = 1;
        repeat (15) tick();
        chk("abort_no_valid", ov_seen - base, 0);
        iv[0] = 1;
        tick();
        iv[0] = 0;
        repeat (10) tick();
        chk("post_abort_valid", ov[0], 1);
        chk("post_abort_ct", ob[0], CT_B);
        out_ready = 1;
        tick();
        out_ready = 0;

        // Random key.
        expand(0, {rand128(), 128'h0}, 10);
        r1 = rand128();
        in_block = r1;
        iv[0] = 1;
        tick();
        iv[0] = 0;
        repeat (10) tick();
        chk("rkey_ct", ob[0], aes_ref(r1, 0, 10));
        out_ready = 1;
        tick();
        out_ready = 0;

        // App. C.1/C.2/C.3 on all three round counts side by side.
        expand(0, KEY_C1, 10);
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
        for (int k = 0; k < 3; k++) chk("c_rk_idx0", ridx[k], 0);
        in_block = PT_C;
        iv = 3'b111;
        tick();
        iv = '0;
        for (int t = 1; t <= 15; t++) begin
            for (int k = 0; k < 3; k++) begin
                chk("c_rk_idx", ridx[k], (t < 10 + 2 * k) ? t : 10 + 2 * k);
                chk("c_valid", ov[k], t > 10 + 2 * k);
            end
            tick();
        end
        chk("c1_ct", ob[0], CT_C1);
        chk("c2_ct", ob[1], CT_C2);
        chk("c3_ct", ob[2], CT_C3);
        out_ready = 1;
        tick();
        chk("c_idle", ir, 3'b111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
